// File: rtl/deserializador.sv
// Serial-to-parallel receiver for the 8-bit serializer stream (MSB first).
// Hunts for a comma byte to recover word alignment, confirms it with a run of
// boundary-aligned commas, then emits one parallel word per 8 clocks with a
// one-cycle valid strobe. Repeated misaligned commas while locked drop lock.
module deserializador #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter int unsigned LOCK_CNT   = 2,
    parameter int unsigned UNLOCK_CNT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in,
    input  logic       DK,
    output logic [7:0] data_out,
    output logic       dk_out,
    output logic       valid_out,
    output logic       locked
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_TH   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_TH = 4'(UNLOCK_CNT);

    state_t     state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] fill_cnt_q, fill_cnt_d;
    logic [3:0] comma_cnt_q, comma_cnt_d;
    logic [3:0] err_cnt_q, err_cnt_d;
    logic [7:0] data_q, data_d;
    logic       dk_q, dk_d;
    logic       valid_q, valid_d;
    logic       locked_q, locked_d;

    logic [7:0] win;
    logic       hit;
    logic       boundary;
    logic [3:0] comma_inc;
    logic [3:0] err_inc;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Byte completed on this edge; a comma only counts once the shift
    // register holds 8 real bits, so reset contents never alias a comma.
    assign win       = {sr_q[6:0], in};
    assign hit       = (fill_cnt_q >= 4'd7) && (win == COMMA);
    assign boundary  = (bit_cnt_q == 3'd7);
    assign comma_inc = sat_inc(comma_cnt_q);
    assign err_inc   = sat_inc(err_cnt_q);

    // Next-state, counter and output computation for the alignment FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        sr_d        = win;
        bit_cnt_d   = bit_cnt_q + 3'd1;
        fill_cnt_d  = (fill_cnt_q == 4'd8) ? fill_cnt_q : fill_cnt_q + 4'd1;
        comma_cnt_d = comma_cnt_q;
        err_cnt_d   = err_cnt_q;
        data_d      = data_q;
        dk_d        = dk_q;
        valid_d     = 1'b0;

        case (state_q)
            SEARCH: begin
                if (hit) begin
                    // The comma defines the word boundary: the next one lands 8 edges on.
                    bit_cnt_d   = 3'd0;
                    comma_cnt_d = 4'd1;
                    if (LOCK_TH <= 4'd1) begin
                        state_d   = LOCKED;
                        err_cnt_d = 4'd0;
                    end else begin
                        state_d = ACQUIRE;
                    end
                end
            end

            ACQUIRE: begin
                if (boundary) begin
                    if (hit) begin
                        comma_cnt_d = comma_inc;
                        if (comma_inc >= LOCK_TH) begin
                            state_d   = LOCKED;
                            err_cnt_d = 4'd0;
                        end
                    end else begin
                        state_d     = SEARCH;
                        comma_cnt_d = 4'd0;
                    end
                end
            end

            LOCKED: begin
                if (boundary) begin
                    // Every aligned word goes out, idles included; dk_out tells them apart.
                    data_d  = win;
                    dk_d    = DK;
                    valid_d = 1'b1;
                    if (hit) begin
                        err_cnt_d = 4'd0;
                    end
                end else if (hit) begin
                    err_cnt_d = err_inc;
                    if (err_inc >= UNLOCK_TH) begin
                        state_d     = SEARCH;
                        comma_cnt_d = 4'd0;
                        err_cnt_d   = 4'd0;
                    end
                end
            end

            default: begin
                state_d     = SEARCH;
                comma_cnt_d = 4'd0;
                err_cnt_d   = 4'd0;
            end
        endcase
    end

    assign locked_d = (state_d == LOCKED);

    // State and datapath registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q     <= SEARCH;
            sr_q        <= 8'h00;
            bit_cnt_q   <= 3'd0;
            fill_cnt_q  <= 4'd0;
            comma_cnt_q <= 4'd0;
            err_cnt_q   <= 4'd0;
            data_q      <= 8'h00;
            dk_q        <= 1'b0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            fill_cnt_q  <= fill_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            err_cnt_q   <= err_cnt_d;
            data_q      <= data_d;
            dk_q        <= dk_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
        end
    end

    assign data_out  = data_q;
    assign dk_out    = dk_q;
    assign valid_out = valid_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_deserializador.sv
// Directed bench for deserializador: a byte-level vector table plus
// hand-written sequences for alignment, loss of lock and mid-word reset.
module tb_deserializador;

    logic       clk;
    logic       reset;
    logic       in;
    logic       DK;
    logic [7:0] data_out;
    logic       dk_out;
    logic       valid_out;
    logic       locked;

    logic [7:0] z_data_out;
    logic       z_dk_out;
    logic       z_valid_out;
    logic       z_locked;

    int n_checks = 0;
    int n_pass   = 0;
    int pulse_cnt = 0;

    deserializador dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .DK        (DK),
        .data_out  (data_out),
        .dk_out    (dk_out),
        .valid_out (valid_out),
        .locked    (locked)
    );

    // Second instance with an all-zero comma to exercise the fill guard.
    deserializador #(.COMMA(8'h00)) dut_z (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .DK        (DK),
        .data_out  (z_data_out),
        .dk_out    (z_dk_out),
        .valid_out (z_valid_out),
        .locked    (z_locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] byte_in;
        logic       dk_in;
        logic       exp_locked;
        int         exp_pulses;
        logic [7:0] exp_data;
        logic       exp_dk;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic dk);
        in = b;
        DK = dk;
        @(posedge clk);
        #1;
        if (valid_out === 1'b1) pulse_cnt++;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dk);
        for (int i = 7; i >= 0; i--) send_bit(b[i], dk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in    = 1'b0;
        DK    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        pulse_cnt = 0;
    endtask

    initial begin
        int p0;
        logic early;
        logic [7:0] bc;

        vecs[0] = '{8'hBC, 1'b0, 1'b0, 0, 8'h00, 1'b0};
        vecs[1] = '{8'hBC, 1'b0, 1'b1, 0, 8'h00, 1'b0};
        vecs[2] = '{8'h5A, 1'b1, 1'b1, 1, 8'h5A, 1'b1};
        vecs[3] = '{8'h33, 1'b0, 1'b1, 1, 8'h33, 1'b0};
        vecs[4] = '{8'hC3, 1'b1, 1'b1, 1, 8'hC3, 1'b1};
        vecs[5] = '{8'hBC, 1'b0, 1'b1, 1, 8'hBC, 1'b0};
        bc = 8'hBC;

        reset = 1'b1;
        in    = 1'b0;
        DK    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset locked", {31'd0, locked}, 32'd0);
        check("reset valid", {31'd0, valid_out}, 32'd0);
        check("reset data", {24'd0, data_out}, 32'd0);
        check("reset dk", {31'd0, dk_out}, 32'd0);
        reset = 1'b0;
        pulse_cnt = 0;

        // Aligned lock, then data words of both DK values, then an idle.
        for (int i = 0; i < 6; i++) begin
            p0 = pulse_cnt;
            send_byte(vecs[i].byte_in, vecs[i].dk_in);
            check($sformatf("vec%0d locked", i), {31'd0, locked}, {31'd0, vecs[i].exp_locked});
            check($sformatf("vec%0d pulses", i), pulse_cnt - p0, vecs[i].exp_pulses);
            check($sformatf("vec%0d data", i), {24'd0, data_out}, {24'd0, vecs[i].exp_data});
            check($sformatf("vec%0d dk", i), {31'd0, dk_out}, {31'd0, vecs[i].exp_dk});
        end

        // Three leading bits shift the word grid; lock must follow the bits.
        do_reset();
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_byte(8'hBC, 1'b0);
        check("shift lock after 11", {31'd0, locked}, 32'd0);
        send_byte(8'hBC, 1'b0);
        check("shift lock after 19", {31'd0, locked}, 32'd1);
        check("shift no pulse yet", pulse_cnt, 0);
        send_byte(8'hA5, 1'b1);
        check("shift pulses", pulse_cnt, 1);
        check("shift data", {24'd0, data_out}, 32'hA5);
        check("shift dk", {31'd0, dk_out}, 32'd1);

        // Zero comma: reset contents must not match before 8 bits arrived.
        do_reset();
        early = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            send_bit(1'b0, 1'b0);
            if (i < 16 && z_locked === 1'b1) early = 1'b1;
        end
        check("zero comma early lock", {31'd0, early}, 32'd0);
        check("zero comma lock at 16", {31'd0, z_locked}, 32'd1);
        check("zero stream main unlocked", {31'd0, locked}, 32'd0);

        // Comma then non-comma drops back to SEARCH: two more commas needed.
        do_reset();
        send_byte(8'hBC, 1'b0);
        send_byte(8'h00, 1'b0);
        check("acq abort locked", {31'd0, locked}, 32'd0);
        send_byte(8'hBC, 1'b0);
        check("acq abort one comma", {31'd0, locked}, 32'd0);
        send_byte(8'hBC, 1'b0);
        check("acq abort relock", {31'd0, locked}, 32'd1);

        // Slip one bit while locked; idles become misaligned commas.
        do_reset();
        send_byte(8'hBC, 1'b0);
        send_byte(8'hBC, 1'b0);
        send_byte(8'hBC, 1'b0);
        p0 = pulse_cnt;
        for (int i = 7; i >= 1; i--) send_bit(bc[i], 1'b0);
        send_byte(8'hBC, 1'b0);
        send_byte(8'hBC, 1'b0);
        check("slip locked after 2 hits", {31'd0, locked}, 32'd1);
        send_byte(8'hBC, 1'b0);
        check("slip unlock on 3rd hit", {31'd0, locked}, 32'd0);
        check("slip pulses before unlock", pulse_cnt - p0, 3);
        check("slip last data", {24'd0, data_out}, 32'h79);
        p0 = pulse_cnt;
        send_byte(8'hBC, 1'b0);
        check("slip still unlocked", {31'd0, locked}, 32'd0);
        send_byte(8'hBC, 1'b0);
        check("slip relock", {31'd0, locked}, 32'd1);
        check("slip no pulses unlocked", pulse_cnt - p0, 0);
        send_byte(8'hBC, 1'b0);
        check("slip first pulse after relock", pulse_cnt - p0, 1);
        check("slip relock data", {24'd0, data_out}, 32'hBC);

        // Reset on bit 4 of a word while locked clears everything.
        do_reset();
        send_byte(8'hBC, 1'b0);
        send_byte(8'hBC, 1'b0);
        send_byte(8'h5A, 1'b1);
        check("pre-reset data", {24'd0, data_out}, 32'h5A);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        reset = 1'b1;
        in    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midword reset locked", {31'd0, locked}, 32'd0);
        check("midword reset valid", {31'd0, valid_out}, 32'd0);
        check("midword reset data", {24'd0, data_out}, 32'd0);
        check("midword reset dk", {31'd0, dk_out}, 32'd0);
        send_byte(8'hBC, 1'b0);
        check("post reset one comma", {31'd0, locked}, 32'd0);
        send_byte(8'hBC, 1'b0);
        check("post reset relock", {31'd0, locked}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
